// File: rtl/bitorder_gearbox.sv
// Width/bit-order gearbox: packs IN_W-bit chunks into WORD_W-bit words and emits OUT_W-bit chunks
// LSB-first. Define PAD_PARTIAL_EN to zero-fill and emit a trailing partial word instead of dropping it.
module bitorder_gearbox #(
   parameter int unsigned IN_W   = 2,
   parameter int unsigned OUT_W  = 2,
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              axiiv,
   input  logic [IN_W-1:0]   axiid,
   input  logic              reverse,
   output logic              axiov,
   output logic [OUT_W-1:0]  axiod,
   output logic              frame_err,
   output logic [CNT_W-1:0]  words_in
);

   localparam int unsigned K_IN  = WORD_W / IN_W;
   localparam int unsigned K_OUT = WORD_W / OUT_W;
   localparam int unsigned ICW   = (K_IN > 1) ? $clog2(K_IN) : 1;
   localparam int unsigned OCW   = (K_OUT > 1) ? $clog2(K_OUT) : 1;
   localparam logic [ICW-1:0] IN_LAST  = ICW'(K_IN - 1);
   localparam logic [OCW-1:0] OUT_LAST = OCW'(K_OUT - 1);

   typedef enum logic {StIdle, StFill} in_state_e;
   typedef enum logic {StOutIdle, StEmit} out_state_e;

   in_state_e          in_st_q, in_st_d;
   logic [ICW-1:0]     in_cnt_q, in_cnt_d;
   logic               rev_q, rev_d;
   logic [WORD_W-1:0]  asm_q, asm_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               err_q, err_d;
   out_state_e         out_st_q, out_st_d;
   logic [OCW-1:0]     out_cnt_q, out_cnt_d;
   logic [WORD_W-1:0]  obuf_q, obuf_d;
   logic               axiov_q, axiov_d;
   logic [OUT_W-1:0]   axiod_q, axiod_d;
`ifdef PAD_PARTIAL_EN
   logic               pend_q, pend_d;
   logic [WORD_W-1:0]  pend_buf_q, pend_buf_d;
   logic               pad_req;
`endif

   logic               rev_eff;
   logic [ICW-1:0]     cnt_eff;
   logic [CNT_W-1:0]   words_base;
   logic [WORD_W-1:0]  base, filled;
   logic [31:0]        pos;
   logic               load;
   logic               out_free;
   logic               ld;
   logic [WORD_W-1:0]  ld_word;

   // Input side: chunk placement, word completion, frame bookkeeping.
   always_comb begin
      rev_eff    = (in_st_q == StIdle) ? reverse : rev_q;
      cnt_eff    = (in_st_q == StIdle) ? '0 : in_cnt_q;
      words_base = (in_st_q == StIdle) ? '0 : words_q;
      pos        = rev_eff ? (WORD_W - (32'(cnt_eff) + 1) * IN_W) : (32'(cnt_eff) * IN_W);
      // Each word starts from zero so a padded partial word has clean unwritten positions.
      base       = (cnt_eff == '0) ? '0 : asm_q;
      filled     = base | (WORD_W'(axiid) << pos);

      in_st_d  = in_st_q;
      in_cnt_d = in_cnt_q;
      rev_d    = rev_q;
      asm_d    = asm_q;
      words_d  = words_q;
      err_d    = 1'b0;
      load     = 1'b0;
`ifdef PAD_PARTIAL_EN
      pad_req  = 1'b0;
`endif

      if (axiiv) begin
         in_st_d = StFill;
         rev_d   = rev_eff;
         asm_d   = filled;
         words_d = words_base;
         if (cnt_eff == IN_LAST) begin
            load     = 1'b1;
            in_cnt_d = '0;
            words_d  = (words_base == '1) ? words_base : words_base + CNT_W'(1);
         end else begin
            in_cnt_d = cnt_eff + ICW'(1);
         end
      end else if (in_st_q == StFill) begin
         in_st_d  = StIdle;
         in_cnt_d = '0;
         if (in_cnt_q != '0) begin
            err_d = 1'b1;
`ifdef PAD_PARTIAL_EN
            pad_req = 1'b1;
            words_d = (words_q == '1) ? words_q : words_q + CNT_W'(1);
`endif
         end
      end
   end

   // Output side: a load may coincide with the last chunk of the previous emission.
   always_comb begin
      out_free  = (out_st_q == StOutIdle) || (out_cnt_q == OUT_LAST);
      out_st_d  = out_st_q;
      out_cnt_d = out_cnt_q;
      obuf_d    = obuf_q;
      axiov_d   = 1'b0;
      axiod_d   = axiod_q;
      ld        = 1'b0;
      ld_word   = filled;
`ifdef PAD_PARTIAL_EN
      pend_d     = pend_q;
      pend_buf_d = pend_buf_q;
`endif

      if (out_st_q == StEmit) begin
         axiov_d = 1'b1;
         axiod_d = obuf_q[out_cnt_q*OUT_W +: OUT_W];
         if (out_cnt_q == OUT_LAST) begin
            out_st_d  = StOutIdle;
            out_cnt_d = '0;
         end else begin
            out_cnt_d = out_cnt_q + OCW'(1);
         end
      end

      if (load) begin
         ld = 1'b1;
`ifdef PAD_PARTIAL_EN
      end else if (pend_q && out_free) begin
         ld         = 1'b1;
         ld_word    = pend_buf_q;
         pend_d     = pad_req;
         pend_buf_d = asm_q;
      end else if (pad_req) begin
         // A short trailing frame can end while the previous word is still going out.
         if (out_free) begin
            ld      = 1'b1;
            ld_word = asm_q;
         end else begin
            pend_d     = 1'b1;
            pend_buf_d = asm_q;
         end
`endif
      end

      if (ld) begin
         obuf_d    = ld_word;
         out_st_d  = StEmit;
         out_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_st_q    <= StIdle;
         in_cnt_q   <= '0;
         rev_q      <= 1'b0;
         asm_q      <= '0;
         words_q    <= '0;
         err_q      <= 1'b0;
         out_st_q   <= StOutIdle;
         out_cnt_q  <= '0;
         obuf_q     <= '0;
         axiov_q    <= 1'b0;
         axiod_q    <= '0;
`ifdef PAD_PARTIAL_EN
         pend_q     <= 1'b0;
         pend_buf_q <= '0;
`endif
      end else begin
         in_st_q    <= in_st_d;
         in_cnt_q   <= in_cnt_d;
         rev_q      <= rev_d;
         asm_q      <= asm_d;
         words_q    <= words_d;
         err_q      <= err_d;
         out_st_q   <= out_st_d;
         out_cnt_q  <= out_cnt_d;
         obuf_q     <= obuf_d;
         axiov_q    <= axiov_d;
         axiod_q    <= axiod_d;
`ifdef PAD_PARTIAL_EN
         pend_q     <= pend_d;
         pend_buf_q <= pend_buf_d;
`endif
      end
   end

   assign axiov     = axiov_q;
   assign axiod     = axiod_q;
   assign frame_err = err_q;
   assign words_in  = words_q;

endmodule

// File: tb/tb_bitorder_gearbox.sv
// Directed bench: three gearbox instances (OUT_W = 2, 8, 4) share one input stream.
module tb_bitorder_gearbox;

   logic        clk = 1'b0;
   logic        rst, axiiv, reverse;
   logic [1:0]  axiid;

   logic        v2, e2, v8, e8, v4, e4;
   logic [1:0]  d2;
   logic [7:0]  d8;
   logic [3:0]  d4;
   logic [15:0] w2, w8, w4;

   int checks = 0;
   int errors = 0;

   logic [7:0] wq [4];
   int         nw;
   logic [1:0] last2;
   logic [3:0] last4;
   logic [7:0] last8;

   bitorder_gearbox #(.IN_W(2), .OUT_W(2), .WORD_W(8), .CNT_W(16)) dut2 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .reverse(reverse),
      .axiov(v2), .axiod(d2), .frame_err(e2), .words_in(w2));
   bitorder_gearbox #(.IN_W(2), .OUT_W(8), .WORD_W(8), .CNT_W(16)) dut8 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .reverse(reverse),
      .axiov(v8), .axiod(d8), .frame_err(e8), .words_in(w8));
   bitorder_gearbox #(.IN_W(2), .OUT_W(4), .WORD_W(8), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .reverse(reverse),
      .axiov(v4), .axiod(d4), .frame_err(e4), .words_in(w4));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
      tick();
      rst = 1'b0;
      last2 = '0; last4 = '0; last8 = '0;
   endtask

   // Sends wq[0..nw-1] and checks every cycle until one cycle past the last output chunk.
   task automatic run_frame(input logic rev);
      logic [7:0] w;
      int m;
      logic ev2, ev8, ev4;
      for (int k = 0; k < 4 * nw + 5; k++) begin
         axiiv   = (k < 4 * nw);
         reverse = rev;
         if (k < 4 * nw) begin
            w = wq[k/4];
            axiid = rev ? w[(7 - 2 * (k % 4)) -: 2] : w[(2 * (k % 4)) +: 2];
         end
         tick();
         m = k - 4;
         ev2 = 1'b0; ev8 = 1'b0; ev4 = 1'b0;
         if (m >= 0 && m < 4 * nw) begin
            w = wq[m/4];
            ev2 = 1'b1;
            last2 = w[(2 * (m % 4)) +: 2];
            ev8 = (m % 4 == 0);
            if (ev8) last8 = w;
            ev4 = (m % 4 < 2);
            if (ev4) last4 = w[(4 * (m % 4)) +: 4];
         end
         check("axiov_w2", v2, ev2);
         check("axiod_w2", d2, last2);
         check("axiov_w8", v8, ev8);
         check("axiod_w8", d8, last8);
         check("axiov_w4", v4, ev4);
         check("axiod_w4", d4, last4);
         check("frame_err", e2, 0);
         check("words_in", w2, (k < 4 * nw) ? (k + 1) / 4 : nw);
      end
   endtask

   initial begin
      rst = 1'b1; axiiv = 1'b0; axiid = 2'b00; reverse = 1'b0;
      tick();
      tick();
      check("rst_axiov", v2, 0);
      check("rst_axiod", d2, 0);
      check("rst_frame_err", e2, 0);
      check("rst_words_in", w2, 0);
      check("rst_axiod_w8", d8, 0);
      rst = 1'b0;
      last2 = '0; last4 = '0; last8 = '0;

      // Dibits 10,11,01,00 MSB-first -> 0xB4.
      wq[0] = 8'hB4; nw = 1;
      run_frame(1'b1);
      // Same dibits LSB-first -> 0x1E.
      wq[0] = 8'h1E; nw = 1;
      run_frame(1'b0);

      // Back-to-back words, then a fresh frame restarts words_in.
      wq[0] = 8'hB4; wq[1] = 8'h55; wq[2] = 8'h0F; nw = 3;
      run_frame(1'b1);
      wq[0] = 8'h3C; nw = 1;
      run_frame(1'b1);

      // Partial frame: dibits 10,11 then valid drops; padded word would be 0xB0.
      do_reset();
      axiiv = 1'b1; reverse = 1'b1; axiid = 2'b10;
      tick();
      axiid = 2'b11;
      tick();
      axiiv = 1'b0;
      tick();
      check("partial_err_w2", e2, 1);
      check("partial_err_w8", e8, 1);
      check("partial_err_w4", e4, 1);
`ifdef PAD_PARTIAL_EN
      check("partial_words", w2, 1);
`else
      check("partial_words", w2, 0);
`endif
      for (int j = 0; j < 4; j++) begin
         tick();
         if (j == 0) check("partial_err_clr", e2, 0);
`ifdef PAD_PARTIAL_EN
         check("pad_axiov_w2", v2, 1);
         check("pad_axiod_w2", d2, (j == 2) ? 3 : (j == 3) ? 2 : 0);
         check("pad_axiov_w8", v8, j == 0);
         if (j == 0) check("pad_axiod_w8", d8, 8'hB0);
         check("pad_axiov_w4", v4, j < 2);
         if (j == 1) check("pad_axiod_w4", d4, 4'hB);
`else
         check("drop_axiov_w2", v2, 0);
         check("drop_axiod_w2", d2, 0);
         check("drop_axiov_w8", v8, 0);
         check("drop_axiov_w4", v4, 0);
`endif
      end
      tick();
      check("partial_idle", v2, 0);
      check("partial_err_once", e2, 0);

      // Reset during the second output dibit of 0xB4.
      do_reset();
      axiiv = 1'b1; reverse = 1'b1;
      axiid = 2'b10; tick();
      axiid = 2'b11; tick();
      axiid = 2'b01; tick();
      axiid = 2'b00; tick();
      axiiv = 1'b0;
      tick();
      check("pre_rst_d0", d2, 0);
      check("pre_rst_v0", v2, 1);
      tick();
      check("pre_rst_d1", d2, 1);
      check("pre_rst_d4", d4, 4'hB);
      rst = 1'b1;
      tick();
      check("mid_rst_axiov", v2, 0);
      check("mid_rst_axiod", d2, 0);
      check("mid_rst_words", w2, 0);
      check("mid_rst_axiod_w8", d8, 0);
      check("mid_rst_axiod_w4", d4, 0);
      check("mid_rst_axiov_w4", v4, 0);
      rst = 1'b0;
      last2 = '0; last4 = '0; last8 = '0;
      wq[0] = 8'h55; wq[1] = 8'hA3; nw = 2;
      run_frame(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
